// File: rtl/lcm_gcd_engine.sv
// Iterative LCM/GCD engine on unsigned W-bit operands. LCM uses repeated addition
// and GCD uses repeated subtraction; the step count is reported alongside the result.
module lcm_gcd_engine #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           go_i,
    input  logic           mode_i,
    input  logic           abort_i,
    input  logic [W-1:0]   x_i,
    input  logic [W-1:0]   y_i,
    output logic [2*W-1:0] d_o,
    output logic           done_o,
    output logic           err_o,
    output logic           busy_o,
    output logic [W:0]     iter_o,
    output logic           dbg_state_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state;
    logic [2*W-1:0] a;
    logic [2*W-1:0] b;
    logic [W-1:0]   x0;
    logic [W-1:0]   y0;
    logic           mode_q;
    logic [W:0]     step;

    // Handshake: a request (go_i with mode_i, x_i, y_i) is taken only while busy_o
    // is low; one done_o pulse answers it unless abort_i or reset cancels the run.
    assign busy_o      = (state == RUN);
    assign dbg_state_o = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            a      <= '0;
            b      <= '0;
            x0     <= '0;
            y0     <= '0;
            mode_q <= 1'b0;
            step   <= '0;
            d_o    <= '0;
            iter_o <= '0;
            done_o <= 1'b0;
            err_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (go_i) begin
                        a      <= {{W{1'b0}}, x_i};
                        b      <= {{W{1'b0}}, y_i};
                        x0     <= x_i;
                        y0     <= y_i;
                        mode_q <= mode_i;
                        // A zero operand has no meaningful result; answer at once.
                        if (x_i == '0 || y_i == '0) begin
                            d_o    <= '0;
                            iter_o <= '0;
                            err_o  <= 1'b1;
                            done_o <= 1'b1;
                        end else begin
                            step  <= '0;
                            err_o <= 1'b0;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (abort_i) begin
                        state <= IDLE;
                    end else if (a == b) begin
                        d_o    <= a;
                        iter_o <= step;
                        done_o <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        step <= step + 1'b1;
                        if (!mode_q) begin
                            // LCM: advance the smaller multiple by its base operand.
                            if (a < b) a <= a + {{W{1'b0}}, x0};
                            else       b <= b + {{W{1'b0}}, y0};
                        end else begin
                            if (a > b) a <= a - b;
                            else       b <= b - a;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcm_gcd_engine.sv
// Bench for lcm_gcd_engine: directed and randomized requests checked against an
// arithmetic reference (Euclid by division, LCM = x*y/gcd).
module tb_lcm_gcd_engine;
  localparam int W  = 4;
  localparam int W5 = 5;
  localparam int EW = 1 + (W + 1) + 2 * W;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic           go_i = 1'b0;
  logic           mode_i = 1'b0;
  logic           abort_i = 1'b0;
  logic [W-1:0]   x_i = '0;
  logic [W-1:0]   y_i = '0;
  logic [2*W-1:0] d_o;
  logic           done_o, err_o, busy_o, dbg_state;
  logic [W:0]     iter_o;

  logic            go5 = 1'b0;
  logic            mode5 = 1'b1;
  logic            abort5 = 1'b0;
  logic [W5-1:0]   x5 = '0;
  logic [W5-1:0]   y5 = '0;
  logic [2*W5-1:0] d5;
  logic            done5, err5, busy5, dbg5;
  logic [W5:0]     iter5;

  lcm_gcd_engine #(.W(W)) dut (
    .clk(clk), .rst(rst), .go_i(go_i), .mode_i(mode_i), .abort_i(abort_i),
    .x_i(x_i), .y_i(y_i), .d_o(d_o), .done_o(done_o), .err_o(err_o),
    .busy_o(busy_o), .iter_o(iter_o), .dbg_state_o(dbg_state)
  );

  lcm_gcd_engine #(.W(W5)) dut5 (
    .clk(clk), .rst(rst), .go_i(go5), .mode_i(mode5), .abort_i(abort5),
    .x_i(x5), .y_i(y5), .d_o(d5), .done_o(done5), .err_o(err5),
    .busy_o(busy5), .iter_o(iter5), .dbg_state_o(dbg5)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] last_exp = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model: plain arithmetic, no knowledge of the datapath
  task automatic ref_model(input int x, input int y, input int m,
                           output int d, output int st, output int er);
    int a, b, q, t;
    if (x == 0 || y == 0) begin
      d = 0; st = 0; er = 1;
      return;
    end
    a = (x > y) ? x : y;
    b = (x > y) ? y : x;
    q = 0;
    while (b != 0) begin
      q += a / b;
      t = a % b;
      a = b;
      b = t;
    end
    er = 0;
    if (m == 1) begin
      d = a;
      st = q - 1;
    end else begin
      d = (x * y) / a;
      st = d / x + d / y - 2;
    end
  endtask

  // driver: issue one request and follow it to completion
  task automatic do_op(input int x, input int y, input int m,
                       input bit scramble, input bit abort_with_go);
    int d, st, er, cyc;
    logic [EW-1:0] e;
    ref_model(x, y, m, d, st, er);
    exp_q.push_back({er[0], st[W:0], d[2*W-1:0]});
    go_i = 1'b1; x_i = x[W-1:0]; y_i = y[W-1:0]; mode_i = m[0]; abort_i = abort_with_go;
    tick();
    go_i = 1'b0; abort_i = 1'b0;
    e = exp_q.pop_front();
    last_exp = e;
    if (er != 0) begin
      n_vec++;
      if ({done_o, busy_o, err_o, iter_o, d_o} !== {1'b1, 1'b0, e}) begin
        n_err++;
        $display("FAIL zero_op x=%0d y=%0d: got done=%b busy=%b err=%b iter=%0d d=%0d, want done=1 busy=0 err=1 iter=0 d=0",
                 x, y, done_o, busy_o, err_o, iter_o, d_o);
      end
      return;
    end
    n_vec++;
    if (busy_o !== 1'b1 || done_o !== 1'b0) begin
      n_err++;
      $display("FAIL start x=%0d y=%0d m=%0d: got busy=%b done=%b, want busy=1 done=0",
               x, y, m, busy_o, done_o);
    end
    cyc = 0;
    while (done_o !== 1'b1 && cyc <= 300) begin
      if (scramble) begin
        go_i = 1'($urandom_range(0, 1));
        mode_i = 1'($urandom_range(0, 1));
        x_i = W'($urandom_range(0, (1 << W) - 1));
        y_i = W'($urandom_range(0, (1 << W) - 1));
      end
      tick();
      cyc++;
    end
    go_i = 1'b0;
    n_vec++;
    if (cyc != st + 1) begin
      n_err++;
      $display("FAIL latency x=%0d y=%0d m=%0d: got %0d edges, want %0d", x, y, m, cyc, st + 1);
    end
    n_vec++;
    if ({err_o, iter_o, d_o} !== e || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL result x=%0d y=%0d m=%0d: got err=%b iter=%0d d=%0d busy=%b, want err=%0d iter=%0d d=%0d busy=0",
               x, y, m, err_o, iter_o, d_o, busy_o, er, st, d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({d_o, done_o, err_o, busy_o, iter_o, dbg_state} !== '0 ||
        {d5, done5, err5, busy5, iter5} !== '0) begin
      n_err++;
      $display("FAIL reset: got d=%0d done=%b err=%b busy=%b iter=%0d, want all 0",
               d_o, done_o, err_o, busy_o, iter_o);
    end
    #3 rst = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    do_op(4, 6, 0, 1'b0, 1'b0);
    tick();
    n_vec++;
    if (done_o !== 1'b0 || d_o !== 8'd12 || iter_o !== 5'd3) begin
      n_err++;
      $display("FAIL done_pulse_hold: got done=%b d=%0d iter=%0d, want done=0 d=12 iter=3",
               done_o, d_o, iter_o);
    end
    do_op(15, 14, 0, 1'b0, 1'b0);
    do_op(15, 1, 1, 1'b0, 1'b0);
    do_op(1, 15, 0, 1'b0, 1'b0);
    do_op(9, 9, 1, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_gcd_w5();
    int cyc;
    go5 = 1'b1; x5 = 5'd12; y5 = 5'd18;
    tick();
    go5 = 1'b0;
    cyc = 0;
    while (done5 !== 1'b1 && cyc <= 100) begin
      tick();
      cyc++;
    end
    n_vec++;
    if (cyc != 3 || d5 !== 10'd6 || iter5 !== 6'd2 || err5 !== 1'b0) begin
      n_err++;
      $display("FAIL gcd_w5: got edges=%0d d=%0d iter=%0d err=%b, want edges=3 d=6 iter=2 err=0",
               cyc, d5, iter5, err5);
    end
    tick();
  endtask

  task automatic test_zero();
    do_op(0, 9, 0, 1'b0, 1'b0);
    do_op(3, 3, 0, 1'b0, 1'b0);
    do_op(7, 0, 1, 1'b0, 1'b0);
    tick();
    n_vec++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b1) begin
      n_err++;
      $display("FAIL zero_idle: got busy=%b done=%b err=%b, want busy=0 done=0 err=1",
               busy_o, done_o, err_o);
    end
  endtask

  task automatic test_back_to_back();
    do_op(4, 6, 1, 1'b0, 1'b0);
    do_op(5, 3, 0, 1'b0, 1'b0);
    do_op(8, 12, 1, 1'b0, 1'b0);
    do_op(2, 7, 0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_op(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)),
            int'($urandom_range(0, 1)), 1'b1, 1'b0);
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();
  endtask

  task automatic test_abort();
    logic [EW-1:0] prev;
    bit seen;
    do_op(7, 5, 1, 1'b0, 1'b0);
    prev = last_exp;
    go_i = 1'b1; x_i = 4'd15; y_i = 4'd14; mode_i = 1'b0;
    tick();
    go_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (done_o === 1'b1 || busy_o !== 1'b0) seen = 1'b1;
      tick();
    end
    n_vec++;
    if (seen || {err_o, iter_o, d_o} !== prev) begin
      n_err++;
      $display("FAIL abort_run: got stray=%b err=%b iter=%0d d=%0d, want stray=0 err=%b iter=%0d d=%0d",
               seen, err_o, iter_o, d_o, prev[EW-1], prev[2*W +: W+1], prev[2*W-1:0]);
    end
    // abort arriving on the edge that would otherwise complete
    go_i = 1'b1; x_i = 4'd5; y_i = 4'd5; mode_i = 1'b0;
    tick();
    go_i = 1'b0; abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    n_vec++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || {err_o, iter_o, d_o} !== prev) begin
      n_err++;
      $display("FAIL abort_priority: got done=%b busy=%b d=%0d iter=%0d, want done=0 busy=0 d=%0d iter=%0d",
               done_o, busy_o, d_o, iter_o, prev[2*W-1:0], prev[2*W +: W+1]);
    end
    do_op(6, 4, 1, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    go_i = 1'b1; x_i = 4'd15; y_i = 4'd14; mode_i = 1'b0;
    tick();
    go_i = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if ({d_o, done_o, err_o, busy_o, iter_o} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got d=%0d done=%b err=%b busy=%b iter=%0d, want all 0",
               d_o, done_o, err_o, busy_o, iter_o);
    end
    #3 rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done_o === 1'b1 || busy_o === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (seen) begin
      n_err++;
      $display("FAIL reset_discard: got stray done/busy=1, want 0");
    end
    do_op(3, 3, 0, 1'b0, 1'b0);
    do_op(10, 4, 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_gcd_w5();
    test_zero();
    test_back_to_back();
    test_random();
    test_abort();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lcm_gcd_engine.md
LCM_GCD_ENGINE -- requirements
Module: lcm_gcd_engine

Interface
REQ-001 SHALL provide parameter W, default 4, meaning operand width in bits (W >= 2).
REQ-002 SHALL provide clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL provide rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide go_i  input  1  start request, sampled only in IDLE.
REQ-005 SHALL provide mode_i  input  1  operation select: 0 = LCM, 1 = GCD; sampled with go_i.
REQ-006 SHALL provide abort_i  input  1  cancels a running operation.
REQ-007 SHALL provide x_i, y_i  input  W each  operands; sampled with go_i.
REQ-008 SHALL provide d_o  output  2W  registered result.
REQ-009 SHALL provide done_o  output  1  one-cycle completion pulse.
REQ-010 SHALL provide err_o  output  1  registered; set when the last accepted request had a zero operand.
REQ-011 SHALL provide busy_o  output  1  high while in RUN.
REQ-012 SHALL provide iter_o  output  W+1  step count of the last completed operation.

Function
REQ-013 SHALL implement the states IDLE and RUN; busy_o = (state == RUN).
REQ-014 In IDLE with go_i=1, SHALL capture x_i, y_i and mode_i into 2W-bit working registers a, b, base registers x0, y0 and a mode register at that edge (E0).
REQ-015 At E0, if x_i==0 or y_i==0, SHALL remain in IDLE and, in the same edge, set d_o=0, err_o=1, iter_o=0 and pulse done_o.
REQ-016 At E0 with both operands nonzero, SHALL enter RUN, clear the step counter and set err_o=0.
REQ-017 In RUN, LCM mode, each edge with a!=b SHALL perform one step: if a<b then a<=a+x0, else b<=b+y0.
REQ-018 In RUN, GCD mode, each edge with a!=b SHALL perform one step: if a>b then a<=a-b, else b<=b-a.
REQ-019 Each step SHALL increment the step counter by 1.
REQ-020 In RUN, at the first edge where a==b, SHALL set d_o<=a, iter_o<=step count and done_o<=1, and SHALL return to IDLE.
REQ-021 Latency SHALL be exactly steps+1 edges after E0; equal operands complete at E0+1 with iter_o=0.
REQ-022 done_o SHALL be high for exactly one cycle per completion and low otherwise.
REQ-023 d_o, iter_o and err_o SHALL hold their values until the next completion or error.
REQ-024 Arithmetic SHALL be unsigned on 2W bits; the LCM result is at most (2^W-1)^2 and SHALL never overflow.
REQ-025 Step count SHALL be at most 2^(W+1)-4 for LCM and 2^W-2 for GCD, and SHALL fit in W+1 bits without wrap.
REQ-026 go_i, mode_i, x_i and y_i SHALL be ignored while in RUN; changing them SHALL NOT alter the running operation.
REQ-027 abort_i=1 in RUN SHALL return to IDLE at the next edge, with no done_o pulse and d_o, iter_o and err_o unchanged; abort_i takes priority over completion at the same edge.
REQ-028 abort_i SHALL be ignored in IDLE; go_i=1 together with abort_i=1 in IDLE SHALL start normally.
REQ-029 A new go_i SHALL be accepted in the cycle immediately after done_o; back-to-back operations SHALL be supported.

Reset
REQ-030 rst=0 SHALL immediately, independent of clk, force state=IDLE, a=b=x0=y0=0, step counter=0, d_o=0, iter_o=0, done_o=0, err_o=0 and busy_o=0.
REQ-031 Reset asserted in RUN SHALL discard the operation with no done_o pulse; after rst returns high, the first go_i SHALL be accepted normally.

Verification
REQ-032 LCM, W=4: go with x=4, y=6, mode=0 -> busy for 4 cycles; done_o at E0+4; d_o=12, iter_o=3, err_o=0.
REQ-033 GCD: go with x=12, y=18 (W=5), mode=1 -> done_o at E0+3; d_o=6, iter_o=2.
REQ-034 Worst case, W=4: LCM(15,14) -> d_o=210, iter_o=27; GCD(15,1) -> d_o=1, iter_o=14.
REQ-035 Zero operand: go with x=0, y=9 -> at E0 done_o=1, err_o=1, d_o=0, busy_o never asserts; a following LCM(3,3) -> d_o=3, iter_o=0, err_o=0.
REQ-036 Abort and reset: start LCM(15,14), assert abort_i at E0+5 -> IDLE with no done_o and previous d_o retained; restart, then pull rst low mid-RUN -> all outputs 0 asynchronously.
REQ-037 go_i toggling and operand changes during RUN SHALL NOT alter the result; a back-to-back go_i in the cycle after done_o SHALL be accepted.
